// File: rtl/usb_pkg.sv
//------------------------------------------------------------------------------
// usb_pkg : PID constants, token FSM states and the token CRC5 helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package usb_pkg;

  localparam logic [3:0] C_PID_OUT   = 4'h1;
  localparam logic [3:0] C_PID_IN    = 4'h9;
  localparam logic [3:0] C_PID_SOF   = 4'h5;
  localparam logic [3:0] C_PID_SETUP = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PID   = 3'd1,
    ST_B1    = 3'd2,
    ST_B2    = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Reflected form: bit 0 of the result is the first CRC bit on the wire,
  // so it lines up directly with byte2[7:3].
  function automatic logic [4:0] crc5_11(input logic [10:0] field);
    logic [4:0] crc;
    logic       fb;
    crc = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb  = crc[0] ^ field[i];
      crc = {1'b0, crc[4:1]} ^ (fb ? 5'b10100 : 5'b00000);
    end
    return ~crc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_token_rx.sv
//------------------------------------------------------------------------------
// usb_token_rx : decodes USB token packets (PID, addr/endp or frame, CRC5).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module usb_token_rx
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_eop,
  output logic       tok_done,
  output logic       tok_ok,
  output logic [3:0] tok_pid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic       pid_err,
  output logic       crc_err,
  output logic       len_err,
  output logic       busy
);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_pid_byte, r_byte1, r_byte2;
  logic [7:0]  w_pid_byte, w_byte1, w_byte2;
  logic [10:0] w_field;
  logic        w_busy, w_eval, w_cap_pid, w_cap_b1, w_cap_b2, w_len_ok;
  logic        w_pid_bad, w_crc_bad;
  logic        r_done, r_ok, r_pid_err, r_crc_err, r_len_err;
  logic [3:0]  r_pid, r_endp;
  logic [6:0]  r_addr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (rx_valid) w_next = ST_PID;
      ST_PID:   if (rx_valid) w_next = ST_B1;
      ST_B1:    if (rx_valid) w_next = ST_B2;
      ST_B2:    if (rx_valid) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_DRAIN;
      default:  w_next = ST_IDLE;
    endcase
    if (rx_eop) w_next = ST_IDLE;
  end

  // A coincident byte is counted before the end-of-packet is judged.
  always_comb begin
    w_busy    = (r_state != ST_IDLE);
    w_eval    = rx_eop && (w_busy || rx_valid);
    w_cap_pid = rx_valid && (r_state == ST_IDLE);
    w_cap_b1  = rx_valid && (r_state == ST_PID);
    w_cap_b2  = rx_valid && (r_state == ST_B1);
    w_len_ok  = (r_state == ST_B2 && !rx_valid) || (r_state == ST_B1 && rx_valid);
  end

  always_comb begin
    w_pid_byte = w_cap_pid ? rx_data : r_pid_byte;
    w_byte1    = w_cap_b1  ? rx_data : r_byte1;
    w_byte2    = w_cap_b2  ? rx_data : r_byte2;
    w_field    = {w_byte2[2:0], w_byte1};
    w_pid_bad  = (w_pid_byte[7:4] != ~w_pid_byte[3:0]) ||
                 !(w_pid_byte[3:0] inside {C_PID_OUT, C_PID_IN, C_PID_SOF, C_PID_SETUP});
    w_crc_bad  = w_len_ok && (w_byte2[7:3] != crc5_11(w_field));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pid_byte <= 8'h00;
      r_byte1    <= 8'h00;
      r_byte2    <= 8'h00;
    end else begin
      if (w_cap_pid) r_pid_byte <= rx_data;
      if (w_cap_b1)  r_byte1    <= rx_data;
      if (w_cap_b2)  r_byte2    <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_pid     <= 4'h0;
      r_addr    <= 7'h00;
      r_endp    <= 4'h0;
      r_pid_err <= 1'b0;
      r_crc_err <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_done <= w_eval;
      if (w_eval) begin
        r_ok      <= !(w_pid_bad || w_crc_bad || !w_len_ok);
        r_pid     <= w_pid_byte[3:0];
        r_addr    <= w_field[6:0];
        r_endp    <= w_field[10:7];
        r_pid_err <= w_pid_bad;
        r_crc_err <= w_crc_bad;
        r_len_err <= !w_len_ok;
      end
    end
  end

  assign tok_done = r_done;
  assign tok_ok   = r_ok;
  assign tok_pid  = r_pid;
  assign tok_addr = r_addr;
  assign tok_endp = r_endp;
  assign pid_err  = r_pid_err;
  assign crc_err  = r_crc_err;
  assign len_err  = r_len_err;
  assign busy     = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_usb_token_rx.sv
//------------------------------------------------------------------------------
// tb_usb_token_rx : directed and random token packets against a packet model.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_usb_token_rx;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_eop = 1'b0;
  logic       tok_done, tok_ok, pid_err, crc_err, len_err, busy;
  logic [3:0] tok_pid, tok_endp;
  logic [6:0] tok_addr;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] pkt[$];
  logic [3:0] exp_pid;
  logic       exp_ok;

  usb_token_rx dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_eop(rx_eop),
    .tok_done(tok_done), .tok_ok(tok_ok), .tok_pid(tok_pid), .tok_addr(tok_addr),
    .tok_endp(tok_endp), .pid_err(pid_err), .crc_err(crc_err), .len_err(len_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Textbook shift-left CRC5, then reordered so the first wire bit is bit 0.
  function automatic logic [4:0] ref_crc(input logic [10:0] f);
    logic [4:0] r;
    logic [4:0] inv;
    logic       fb;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = r[4] ^ f[i];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    inv = ~r;
    return {inv[0], inv[1], inv[2], inv[3], inv[4]};
  endfunction

  task automatic drive_byte(input logic [7:0] b, input logic eop);
    rx_data = b; rx_valid = 1'b1; rx_eop = eop;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic drive_eop();
    rx_eop = 1'b1;
    @(posedge clk); #1;
    rx_eop = 1'b0;
  endtask

  task automatic check_result(input string tag);
    logic [7:0]  b0, b1, b2;
    logic [10:0] f;
    logic        p_ok, l_ok, c_bad;
    int          n;
    n    = pkt.size();
    b0   = pkt[0];
    b1   = (n > 1) ? pkt[1] : 8'h00;
    b2   = (n > 2) ? pkt[2] : 8'h00;
    f    = {b2[2:0], b1};
    p_ok = (b0[7:4] == ~b0[3:0]) &&
           (b0[3:0] == 4'h1 || b0[3:0] == 4'h9 || b0[3:0] == 4'h5 || b0[3:0] == 4'hD);
    l_ok = (n == 3);
    c_bad = l_ok && (b2[7:3] != ref_crc(f));
    exp_pid = b0[3:0];
    exp_ok  = p_ok && l_ok && !c_bad;
    check({tag, ".done"},    tok_done, 1);
    check({tag, ".pid"},     tok_pid, exp_pid);
    check({tag, ".pid_err"}, pid_err, !p_ok);
    check({tag, ".len_err"}, len_err, !l_ok);
    check({tag, ".crc_err"}, crc_err, c_bad);
    check({tag, ".ok"},      tok_ok, exp_ok);
    check({tag, ".busy"},    busy, 0);
    if (l_ok) begin
      check({tag, ".addr"}, tok_addr, f[6:0]);
      check({tag, ".endp"}, tok_endp, f[10:7]);
    end
  endtask

  task automatic send(input string tag, input bit coinc);
    for (int i = 0; i < pkt.size(); i++) begin
      drive_byte(pkt[i], coinc && (i == pkt.size() - 1));
      if (!(coinc && (i == pkt.size() - 1))) check({tag, ".busy_mid"}, busy, 1);
    end
    if (!coinc) drive_eop();
    check_result(tag);
  endtask

  task automatic idle_after(input string tag);
    @(posedge clk); #1;
    check({tag, ".pulse_end"}, tok_done, 0);
    check({tag, ".hold_pid"},  tok_pid, exp_pid);
    check({tag, ".hold_ok"},   tok_ok, exp_ok);
  endtask

  initial begin
    logic [10:0] f;
    logic [4:0]  c;
    logic [7:0]  b0;
    logic [3:0]  toks[4];
    int          n, sel, gap;
    bit          coinc;
    toks[0] = 4'h1; toks[1] = 4'h9; toks[2] = 4'h5; toks[3] = 4'hD;

    repeat (2) @(posedge clk);
    #1;
    check("rst.done", tok_done, 0); check("rst.ok", tok_ok, 0);
    check("rst.pid", tok_pid, 0);   check("rst.addr", tok_addr, 0);
    check("rst.endp", tok_endp, 0); check("rst.errs", {pid_err, crc_err, len_err}, 0);
    check("rst.busy", busy, 0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    pkt = '{8'h2D, 8'h00, 8'h10};
    send("setup0", 0);
    check("setup0.ok_const", tok_ok, 1); check("setup0.pid_const", tok_pid, 4'hD);
    check("setup0.addr_const", tok_addr, 0); check("setup0.endp_const", tok_endp, 0);
    idle_after("setup0");

    f = {4'hE, 7'h15};
    c = ref_crc(f);
    pkt = '{8'hE1, 8'h15, {c, 3'b111}};
    send("out15", 0);
    check("out15.addr_const", tok_addr, 7'h15); check("out15.endp_const", tok_endp, 4'hE);
    idle_after("out15");

    pkt = '{8'hE1, 8'h15, 8'hBE};
    send("crcbad", 1);
    check("crcbad.crc_const", crc_err, 1);
    idle_after("crcbad");
    pkt = '{8'hE2, 8'h00, 8'h10}; send("pidchk", 0); idle_after("pidchk");
    pkt = '{8'hC3, 8'h00, 8'h10}; send("data0", 0);  idle_after("data0");
    pkt = '{8'h2D, 8'h00};               send("len2", 0); idle_after("len2");
    pkt = '{8'h2D, 8'h00, 8'h10, 8'h55}; send("len4", 1); idle_after("len4");
    pkt = '{8'h69};                      send("len1", 1); idle_after("len1");

    drive_eop();
    check("lone_eop.done", tok_done, 0);
    check("lone_eop.hold", tok_pid, exp_pid);

    pkt = '{8'h2D, 8'h00, 8'h10}; send("pre_rst", 0);
    drive_byte(8'hE1, 0);
    drive_byte(8'h15, 0);
    n_rst = 1'b0; #2;
    check("midrst.ok", tok_ok, 0);     check("midrst.pid", tok_pid, 0);
    check("midrst.busy", busy, 0);     check("midrst.errs", {pid_err, crc_err, len_err}, 0);
    n_rst = 1'b1;
    @(posedge clk); #1;
    drive_eop();
    check("midrst.no_done", tok_done, 0);
    check("midrst.pid_zero", tok_pid, 0);
    check("midrst.addr_zero", tok_addr, 0);
    pkt = '{8'h2D, 8'h00, 8'h10}; send("post_rst", 0); idle_after("post_rst");

    pkt = '{8'hE1, 8'h15, {c, 3'b111}}; send("b2b_a", 1);
    pkt = '{8'h2D, 8'h00, 8'h10};       send("b2b_b", 1);
    idle_after("b2b_b");

    for (int k = 0; k < 40; k++) begin
      n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 3;
      sel = $urandom_range(0, 5);
      if (sel < 4)       b0 = {~toks[sel], toks[sel]};
      else if (sel == 4) b0 = 8'($urandom);
      else               b0 = {~toks[k % 4] ^ 4'h4, toks[k % 4]};
      f = 11'($urandom);
      c = ref_crc(f);
      if ($urandom_range(0, 3) == 0) c = c ^ 5'($urandom_range(1, 31));
      pkt = '{b0, f[7:0], {c, f[10:8]}, 8'($urandom), 8'($urandom)};
      while (pkt.size() > n) void'(pkt.pop_back());
      coinc = 1'($urandom_range(0, 1));
      gap   = $urandom_range(0, 2);
      send($sformatf("rnd%0d", k), coinc);
      if (gap > 0) idle_after($sformatf("rnd%0d", k));
      if (gap > 1) @(posedge clk);
      #0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
